// File: rtl/reg_universal_ctl_if.sv
// Bus interface for reg_universal_ctl: parallel data, control, command
// handshake and register outputs. The clock and reset are not part of the bus.
interface reg_universal_ctl_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] d;
  logic             ld;
  logic             en;
  logic [2:0]       op;
  logic             sin;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] Q;
  logic             sout;
  logic             carry;
  logic             busy;
  logic             done;

  modport master (
    output d, ld, en, op, sin, start, amt,
    input  Q, sout, carry, busy, done
  );

  modport slave (
    input  d, ld, en, op, sin, start, amt,
    output Q, sout, carry, busy, done
  );
endinterface

// File: rtl/reg_universal_ctl.sv
// Universal WIDTH-bit register clocked on the falling edge: parallel load,
// single-step shift/rotate/count, and a multi-cycle shift-by-N command with
// a busy/done handshake. Asynchronous active-low reset.
// Define REG_UNIVERSAL_COUNT_EN to build the inc/dec ops and the carry flag;
// without it ops 110/111 hold and carry is tied low.
module reg_universal_ctl #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clock,
  input logic reset_n,
  reg_universal_ctl_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             zeroPend_q, zeroPend_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       opL_q, opL_d;

  logic [2:0]       stepOp;
  logic [WIDTH-1:0] stepQ;
  logic             stepSout;

`ifdef REG_UNIVERSAL_COUNT_EN
  logic carry_q, carry_d;
  logic stepCarry;
`endif

  // Result of one step of the current op: latched op while running, live op otherwise.
  always_comb begin
    stepOp   = (state_q == RUN) ? opL_q : bus.op;
    stepQ    = q_q;
    stepSout = sout_q;
`ifdef REG_UNIVERSAL_COUNT_EN
    stepCarry = carry_q;
`endif
    case (stepOp)
      3'b001: begin
        stepQ    = {q_q[WIDTH-2:0], bus.sin};
        stepSout = q_q[WIDTH-1];
      end
      3'b010: begin
        stepQ    = {bus.sin, q_q[WIDTH-1:1]};
        stepSout = q_q[0];
      end
      3'b011: begin
        stepQ    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        stepSout = q_q[WIDTH-1];
      end
      3'b100: begin
        stepQ    = {q_q[0], q_q[WIDTH-1:1]};
        stepSout = q_q[0];
      end
      3'b101: begin
        stepQ    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        stepSout = q_q[0];
      end
`ifdef REG_UNIVERSAL_COUNT_EN
      3'b110: begin
        stepQ     = q_q + 1'b1;
        stepCarry = &q_q;
      end
      3'b111: begin
        stepQ     = q_q - 1'b1;
        stepCarry = ~|q_q;
      end
`endif
      default: ;
    endcase
  end

  // Next-state logic: load > multi-cycle start > single step in IDLE; RUN ignores inputs.
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    sout_d     = sout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    zeroPend_d = 1'b0;
    cnt_d      = cnt_q;
    opL_d      = opL_q;
`ifdef REG_UNIVERSAL_COUNT_EN
    carry_d = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (zeroPend_q) begin
          done_d = 1'b1;
        end
        if (bus.ld) begin
          q_d = bus.d;
        end else if (bus.start && (bus.op >= 3'd1) && (bus.op <= 3'd5)) begin
          if (bus.amt != '0) begin
            opL_d   = bus.op;
            cnt_d   = bus.amt;
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            zeroPend_d = 1'b1;
          end
        end else if (bus.start) begin
          state_d = IDLE;
        end else if (bus.en) begin
          q_d    = stepQ;
          sout_d = stepSout;
`ifdef REG_UNIVERSAL_COUNT_EN
          carry_d = stepCarry;
`endif
        end
      end
      RUN: begin
        q_d    = stepQ;
        sout_d = stepSout;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, updated on the falling clock edge.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      q_q        <= RESET_VAL;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zeroPend_q <= 1'b0;
      cnt_q      <= '0;
      opL_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zeroPend_q <= zeroPend_d;
      cnt_q      <= cnt_d;
      opL_q      <= opL_d;
    end
  end

`ifdef REG_UNIVERSAL_COUNT_EN
  // Count wrap flag register.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end
  assign bus.carry = carry_q;
`else
  assign bus.carry = 1'b0;
`endif

  assign bus.Q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_reg_universal_ctl.sv
// Self-checking bench for reg_universal_ctl (WIDTH=8, RESET_VAL=A5):
// directed steps from the test plan followed by randomized traffic checked
// against an arithmetic reference model.
module tb_reg_universal_ctl;
  logic clock;
  logic reset_n;
  int   checks;
  int   fails;

  int   mQ;
  int   mSout;
  int   mCarry;
  int   mBusy;
  int   mDone;

  reg_universal_ctl_if #(.WIDTH(8)) bus ();

  reg_universal_ctl #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ldV, input logic [7:0] dV, input logic enV,
                               input logic [2:0] opV, input logic sinV,
                               input logic startV, input logic [3:0] amtV);
    bus.ld    = ldV;
    bus.d     = dV;
    bus.en    = enV;
    bus.op    = opV;
    bus.sin   = sinV;
    bus.start = startV;
    bus.amt   = amtV;
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".Q"}, bus.Q, mQ);
    checkOutput({tag, ".sout"}, bus.sout, mSout);
    checkOutput({tag, ".carry"}, bus.carry, mCarry);
    checkOutput({tag, ".busy"}, bus.busy, mBusy);
    checkOutput({tag, ".done"}, bus.done, mDone);
  endtask

  // Reference model of one step, written as plain arithmetic on 0..255.
  task automatic modelOp(input int op, input int s);
    case (op)
      1: begin mSout = mQ / 128; mQ = (mQ * 2 + s) % 256; end
      2: begin mSout = mQ % 2;   mQ = mQ / 2 + s * 128; end
      3: begin mSout = mQ / 128; mQ = (mQ * 2) % 256 + mQ / 128; end
      4: begin mSout = mQ % 2;   mQ = mQ / 2 + (mQ % 2) * 128; end
      5: begin mSout = mQ % 2;   mQ = mQ / 2 + (mQ / 128) * 128; end
`ifdef REG_UNIVERSAL_COUNT_EN
      6: begin mCarry = (mQ == 255) ? 1 : 0; mQ = (mQ + 1) % 256; end
      7: begin mCarry = (mQ == 0) ? 1 : 0;   mQ = (mQ + 255) % 256; end
`endif
      default: ;
    endcase
  endtask

  initial begin
    int kind;
    int op;
    int amt;
    int s;
    checks = 0;
    fails  = 0;
    applyStimulus(0, 8'h00, 0, 3'b000, 0, 0, 4'd0);

    // Reset assertion
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checkOutput("rst.Q", bus.Q, 8'hA5);
    checkOutput("rst.busy", bus.busy, 0);
    checkOutput("rst.done", bus.done, 0);
    checkOutput("rst.sout", bus.sout, 0);
    checkOutput("rst.carry", bus.carry, 0);
    tick();
    reset_n = 1'b1;

    // Parallel load
    applyStimulus(1, 8'h3C, 0, 3'b000, 0, 0, 4'd0);
    tick();
    checkOutput("ld3C.Q", bus.Q, 8'h3C);

    // Single-step shl with sin=1
    applyStimulus(1, 8'h81, 0, 3'b000, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 8'h00, 1, 3'b001, 1, 0, 4'd0);
    tick();
    checkOutput("shl.Q", bus.Q, 8'h03);
    checkOutput("shl.sout", bus.sout, 1);

    // Single-step asr
    applyStimulus(1, 8'h80, 0, 3'b000, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 8'h00, 1, 3'b101, 0, 0, 4'd0);
    tick();
    checkOutput("asr.Q", bus.Q, 8'hC0);
    checkOutput("asr.sout", bus.sout, 0);

    // Multi-cycle rotate left by 3 with ld asserted mid-run
    applyStimulus(1, 8'h01, 0, 3'b000, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 8'h00, 0, 3'b011, 0, 1, 4'd3);
    tick();
    checkOutput("rol.start.Q", bus.Q, 8'h01);
    checkOutput("rol.start.busy", bus.busy, 1);
    checkOutput("rol.start.done", bus.done, 0);
    applyStimulus(1, 8'hFF, 1, 3'b111, 1, 1, 4'd7);
    tick();
    checkOutput("rol.s1.Q", bus.Q, 8'h02);
    checkOutput("rol.s1.busy", bus.busy, 1);
    checkOutput("rol.s1.done", bus.done, 0);
    tick();
    checkOutput("rol.s2.Q", bus.Q, 8'h04);
    checkOutput("rol.s2.done", bus.done, 0);
    tick();
    checkOutput("rol.s3.Q", bus.Q, 8'h08);
    checkOutput("rol.s3.busy", bus.busy, 0);
    checkOutput("rol.s3.done", bus.done, 1);
    applyStimulus(0, 8'h00, 0, 3'b000, 0, 0, 4'd0);
    tick();
    checkOutput("rol.after.done", bus.done, 0);
    checkOutput("rol.after.Q", bus.Q, 8'h08);

    // amt=0: done one edge after start, busy never rises
    applyStimulus(0, 8'h00, 0, 3'b001, 1, 1, 4'd0);
    tick();
    checkOutput("amt0.e1.busy", bus.busy, 0);
    checkOutput("amt0.e1.done", bus.done, 0);
    checkOutput("amt0.e1.Q", bus.Q, 8'h08);
    applyStimulus(0, 8'h00, 0, 3'b000, 0, 0, 4'd0);
    tick();
    checkOutput("amt0.e2.busy", bus.busy, 0);
    checkOutput("amt0.e2.done", bus.done, 1);
    checkOutput("amt0.e2.Q", bus.Q, 8'h08);
    tick();
    checkOutput("amt0.e3.done", bus.done, 0);

    // amt=WIDTH rotate right returns the original value
    applyStimulus(1, 8'h96, 0, 3'b000, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 8'h00, 0, 3'b100, 0, 1, 4'd8);
    tick();
    checkOutput("ror8.start.busy", bus.busy, 1);
    applyStimulus(0, 8'h00, 0, 3'b000, 0, 0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("ror8.s%0d.busy", i + 1), bus.busy, (i < 7) ? 1 : 0);
      checkOutput($sformatf("ror8.s%0d.done", i + 1), bus.done, (i == 7) ? 1 : 0);
    end
    checkOutput("ror8.Q", bus.Q, 8'h96);

    // Counting: inc from FF then dec from 00
    applyStimulus(1, 8'hFF, 0, 3'b000, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 8'h00, 1, 3'b110, 0, 0, 4'd0);
    tick();
`ifdef REG_UNIVERSAL_COUNT_EN
    checkOutput("inc.Q", bus.Q, 8'h00);
    checkOutput("inc.carry", bus.carry, 1);
`else
    checkOutput("inc.Q", bus.Q, 8'hFF);
    checkOutput("inc.carry", bus.carry, 0);
`endif
    applyStimulus(0, 8'h00, 1, 3'b111, 0, 0, 4'd0);
    tick();
    checkOutput("dec.Q", bus.Q, 8'hFF);
`ifdef REG_UNIVERSAL_COUNT_EN
    checkOutput("dec.carry", bus.carry, 1);
`else
    checkOutput("dec.carry", bus.carry, 0);
`endif

    // Reset during a shl-by-5 after two steps
    applyStimulus(1, 8'h5A, 0, 3'b000, 0, 0, 4'd0);
    tick();
    applyStimulus(0, 8'h00, 0, 3'b001, 1, 1, 4'd5);
    tick();
    applyStimulus(0, 8'h00, 0, 3'b000, 1, 0, 4'd0);
    tick();
    tick();
    checkOutput("rstrun.s2.Q", bus.Q, 8'h6B);
    checkOutput("rstrun.s2.busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstrun.Q", bus.Q, 8'hA5);
    checkOutput("rstrun.busy", bus.busy, 0);
    checkOutput("rstrun.done", bus.done, 0);
    checkOutput("rstrun.sout", bus.sout, 0);
    #2 reset_n = 1'b1;
    mQ = 8'hA5; mSout = 0; mCarry = 0; mBusy = 0; mDone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkModel($sformatf("rstrun.post%0d", i));
    end

    // Randomized traffic against the reference model
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 3);
      mBusy = 0;
      mDone = 0;
      case (kind)
        0: begin
          applyStimulus(1, 8'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                        1'($urandom), 4'($urandom_range(0, 8)));
          tick();
          mQ = bus.d;
          checkModel($sformatf("rnd%0d.ld", it));
        end
        1: begin
          op = $urandom_range(0, 7);
          s  = $urandom_range(0, 1);
          applyStimulus(0, 8'($urandom), 1, 3'(op), 1'(s), 0, 4'($urandom_range(0, 8)));
          tick();
          modelOp(op, s);
          checkModel($sformatf("rnd%0d.en%0d", it, op));
        end
        2: begin
          op  = $urandom_range(1, 5);
          amt = $urandom_range(0, 8);
          applyStimulus(0, 8'($urandom), 1'($urandom), 3'(op), 1'($urandom), 1, 4'(amt));
          tick();
          mBusy = (amt > 0) ? 1 : 0;
          checkModel($sformatf("rnd%0d.start", it));
          if (amt == 0) begin
            applyStimulus(0, 8'h00, 0, 3'b000, 0, 0, 4'd0);
            tick();
            mDone = 1;
            checkModel($sformatf("rnd%0d.zero", it));
          end else begin
            for (int k = 0; k < amt; k++) begin
              s = $urandom_range(0, 1);
              applyStimulus(1'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 1'(s),
                            1'($urandom), 4'($urandom_range(0, 8)));
              tick();
              modelOp(op, s);
              mBusy = (k < amt - 1) ? 1 : 0;
              mDone = (k == amt - 1) ? 1 : 0;
              checkModel($sformatf("rnd%0d.step%0d", it, k));
            end
          end
        end
        default: begin
          case ($urandom_range(0, 2))
            0: op = 0;
            1: op = 6;
            default: op = 7;
          endcase
          applyStimulus(0, 8'($urandom), 1'($urandom), 3'(op), 1'($urandom), 1,
                        4'($urandom_range(0, 8)));
          tick();
          checkModel($sformatf("rnd%0d.ign%0d", it, op));
        end
      endcase
    end

    applyStimulus(0, 8'h00, 0, 3'b000, 0, 0, 4'd0);
    $display("[TB] directed and random phases complete");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
